// File: rtl/rstseq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rstseq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } rstseq_state_e;

endpackage

// File: rtl/rstseq_sync.sv
// Two-flop synchronizer, asynchronous active-low reset to 0.
module rstseq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the asynchronous input down the chain
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: waits for a stable PLL lock, then releases the
// domain resets one by one; lock loss or a software request restarts it.
// Optional lock watchdog enabled by defining RSTSEQ_WDT_EN.
module rst_sequencer
  import rstseq_pkg::*;
#(
  parameter int unsigned N_DOMAINS    = 4,
  parameter int unsigned LOCK_CYCLES  = 16,
  parameter int unsigned STAGE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned WDT_CYCLES   = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pll_lock_i,
  input  logic                 test_mode_i,
  input  logic                 sw_rst_req_i,
  output logic [N_DOMAINS-1:0] rst_no,
  output logic                 ready_o,
  output logic [STATE_W-1:0]   state_o,
  output logic                 lock_lost_o,
  output logic                 lock_timeout_o
);

  localparam int unsigned LockW  = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned StageW = $clog2(STAGE_CYCLES + 1);
  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES + 1);

  // Reject degenerate configurations at elaboration
  if (N_DOMAINS == 0 || LOCK_CYCLES == 0 || STAGE_CYCLES == 0 ||
      HOLD_CYCLES == 0 || WDT_CYCLES == 0) begin : g_bad_params
    $error("rst_sequencer: all domain/cycle parameters must be >= 1");
  end

  logic lock_s;

  rstseq_state_e        state_q, state_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d;
  logic                 ready_q, ready_d;
  logic                 lock_lost_q, lock_lost_d;
  logic [LockW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [StageW-1:0]    stage_cnt_q, stage_cnt_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;

  rstseq_sync u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pll_lock_i),
    .q_o    (lock_s)
  );

  // Next-state and output logic; counters default to cleared outside their state
  always_comb begin
    state_d     = state_q;
    rst_d       = rst_q;
    ready_d     = ready_q;
    lock_lost_d = lock_lost_q;
    lock_cnt_d  = '0;
    stage_cnt_d = '0;
    hold_cnt_d  = '0;

    unique case (state_q)
      RESET: begin
        state_d = WAIT_LOCK;
        rst_d   = '0;
        ready_d = 1'b0;
      end

      WAIT_LOCK: begin
        rst_d   = '0;
        ready_d = 1'b0;
        if (lock_s) begin
          if (lock_cnt_q >= LockW'(LOCK_CYCLES - 1)) begin
            rst_d = N_DOMAINS'(1);
            if (N_DOMAINS == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            lock_cnt_d = lock_cnt_q + LockW'(1);
          end
        end
      end

      RELEASE, RUN: begin
        if (!lock_s) begin
          // lock loss takes priority over a coincident software request
          state_d     = WAIT_LOCK;
          rst_d       = '0;
          ready_d     = 1'b0;
          lock_lost_d = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d = HOLD;
          rst_d   = '0;
          ready_d = 1'b0;
        end else if (state_q == RELEASE) begin
          if (stage_cnt_q >= StageW'(STAGE_CYCLES - 1)) begin
            rst_d = N_DOMAINS'({rst_q, 1'b1});
            if (rst_d[N_DOMAINS-1]) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            stage_cnt_d = stage_cnt_q + StageW'(1);
          end
        end
      end

      HOLD: begin
        rst_d   = '0;
        ready_d = 1'b0;
        if (hold_cnt_q >= HoldW'(HOLD_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end

      default: begin
        state_d = RESET;
        rst_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Output and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_q       <= '0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      lock_cnt_q  <= '0;
      stage_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      lock_cnt_q  <= lock_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

`ifdef RSTSEQ_WDT_EN
  localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);

  logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic            lock_timeout_q, lock_timeout_d;

  // Watchdog: count cycles in WAIT_LOCK, flag at the limit, clear when release starts
  always_comb begin
    wdt_cnt_d      = '0;
    lock_timeout_d = lock_timeout_q;
    if (state_q == WAIT_LOCK) begin
      if (wdt_cnt_q < WdtW'(WDT_CYCLES)) begin
        wdt_cnt_d = wdt_cnt_q + WdtW'(1);
      end else begin
        wdt_cnt_d = wdt_cnt_q;
      end
      if (wdt_cnt_d == WdtW'(WDT_CYCLES)) begin
        lock_timeout_d = 1'b1;
      end
      if (state_d != WAIT_LOCK) begin
        lock_timeout_d = 1'b0;
      end
    end
  end

  // Watchdog registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdt_cnt_q      <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      wdt_cnt_q      <= wdt_cnt_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign lock_timeout_o = lock_timeout_q;
`else
  assign lock_timeout_o = 1'b0;
`endif

  // Test mode hands the domain resets straight to the pad reset
  assign rst_no      = test_mode_i ? {N_DOMAINS{rst_ni}} : rst_q;
  assign ready_o     = ready_q;
  assign state_o     = state_q;
  assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer against a timeline-based reference model.
module tb_rst_sequencer;

  localparam int N     = 4;
  localparam int LOCK  = 16;
  localparam int STAGE = 8;
  localparam int HOLD  = 4;
  localparam int WDT   = 1024;
`ifdef RSTSEQ_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  // model phases: RELEASE and RUN are one phase distinguished by elapsed time
  localparam int P_RESET = 0;
  localparam int P_WAIT  = 1;
  localparam int P_SEQ   = 2;
  localparam int P_HOLD  = 3;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         pll_lock;
  logic         test_mode;
  logic         sw_req;
  logic [N-1:0] rst_no;
  logic         ready;
  logic [2:0]   state;
  logic         lock_lost;
  logic         lock_timeout;

  int n_checks = 0;
  int n_errs   = 0;

  int m_phase, m_streak, m_t, m_hold, m_wait;
  bit m_lost, m_timeout;
  bit hist[$];

  int edge_no;
  int rise[N];
  int ready_rise;

  rst_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .pll_lock_i     (pll_lock),
    .test_mode_i    (test_mode),
    .sw_rst_req_i   (sw_req),
    .rst_no         (rst_no),
    .ready_o        (ready),
    .state_o        (state),
    .lock_lost_o    (lock_lost),
    .lock_timeout_o (lock_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_RESET;
    m_streak  = 0;
    m_t       = 0;
    m_hold    = 0;
    m_wait    = 0;
    m_lost    = 1'b0;
    m_timeout = 1'b0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  // One clock edge of the reference: lock seen two edges late, phases by elapsed time
  task automatic model_edge();
    bit ls;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    hist.push_back(pll_lock);
    ls = hist.pop_front();
    case (m_phase)
      P_RESET: begin
        m_phase  = P_WAIT;
        m_streak = 0;
        m_wait   = 0;
      end
      P_WAIT: begin
        m_wait++;
        if (m_wait == WDT) m_timeout = WDT_EN;
        if (ls) m_streak++;
        else    m_streak = 0;
        if (m_streak == LOCK) begin
          m_phase   = P_SEQ;
          m_t       = 0;
          m_timeout = 1'b0;
        end
      end
      P_SEQ: begin
        if (!ls) begin
          m_phase  = P_WAIT;
          m_lost   = 1'b1;
          m_streak = 0;
          m_wait   = 0;
        end else if (sw_req) begin
          m_phase = P_HOLD;
          m_hold  = 0;
        end else begin
          m_t++;
        end
      end
      default: begin
        m_hold++;
        if (m_hold == HOLD) begin
          m_phase  = P_WAIT;
          m_streak = 0;
          m_wait   = 0;
        end
      end
    endcase
  endtask

  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] r;
    r = '0;
    if (test_mode) return {N{rst_ni}};
    if (m_phase == P_SEQ)
      for (int k = 0; k < N; k++) if (m_t >= k * STAGE) r[k] = 1'b1;
    return r;
  endfunction

  function automatic bit exp_ready();
    return (m_phase == P_SEQ) && (m_t >= (N - 1) * STAGE);
  endfunction

  function automatic int exp_state();
    case (m_phase)
      P_RESET: return 0;
      P_WAIT:  return 1;
      P_SEQ:   return exp_ready() ? 3 : 2;
      default: return 4;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":rst_no"},       rst_no,       exp_rst());
    chk({tag, ":ready"},        ready,        exp_ready());
    chk({tag, ":state"},        state,        exp_state());
    chk({tag, ":lock_lost"},    lock_lost,    m_lost);
    chk({tag, ":lock_timeout"}, lock_timeout, m_timeout);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    edge_no++;
    model_edge();
    @(negedge clk);
    for (int k = 0; k < N; k++) if (rst_no[k] && rise[k] < 0) rise[k] = edge_no;
    if (ready && ready_rise < 0) ready_rise = edge_no;
    check_all(tag);
  endtask

  task automatic clear_marks();
    edge_no = -1;
    for (int k = 0; k < N; k++) rise[k] = -1;
    ready_rise = -1;
  endtask

  initial begin
    rst_ni    = 1'b0;
    pll_lock  = 1'b0;
    test_mode = 1'b0;
    sw_req    = 1'b0;
    model_reset();
    clear_marks();
    repeat (3) step("por");

    // lock high before edge 0, reset released: staged release timeline
    pll_lock = 1'b1;
    rst_ni   = 1'b1;
    clear_marks();
    repeat (45) step("seq");
    for (int k = 0; k < N; k++) chk($sformatf("rise%0d", k), rise[k], 17 + k * STAGE);
    chk("ready_rise", ready_rise, 17 + (N - 1) * STAGE);

    // software request in RUN: hold, re-lock, full sequence, lock_lost untouched
    repeat ($urandom_range(2, 9)) step("run");
    sw_req = 1'b1;
    step("sw");
    sw_req = 1'b0;
    repeat (4) step("hold");
    repeat (45) step("resync");
    chk("lost_after_sw", lock_lost, 1'b0);

    // software request and lock loss seen on the same edge
    pll_lock = 1'b0;
    step("both");
    step("both");
    sw_req = 1'b1;
    step("both");
    sw_req = 1'b0;
    chk("both_state", state, 3'd1);
    chk("both_lost", lock_lost, 1'b1);

    // software request in WAIT_LOCK is ignored
    sw_req = 1'b1;
    step("sw_wait");
    sw_req = 1'b0;

    // one-cycle lock glitch at lock count 10 restarts the count
    clear_marks();
    pll_lock = 1'b1;
    repeat (10) step("glitch_pre");
    pll_lock = 1'b0;
    step("glitch");
    pll_lock = 1'b1;
    repeat (60) step("glitch_post");
    chk("glitch_rise0", rise[0], 12 + LOCK);
    chk("glitch_ready", ready_rise, 12 + LOCK + (N - 1) * STAGE);

    // lock drop in RUN for a random length, then re-lock
    pll_lock = 1'b0;
    repeat ($urandom_range(3, 8)) step("drop");
    pll_lock = 1'b1;
    repeat (45) step("relock");

    // random lock wobble and software requests
    for (int i = 0; i < 600; i++) begin
      if (pll_lock) begin
        if ($urandom_range(0, 59) == 0) pll_lock = 1'b0;
      end else begin
        if ($urandom_range(0, 5) == 0) pll_lock = 1'b1;
      end
      sw_req = ($urandom_range(0, 24) == 0);
      step("rand");
    end
    sw_req   = 1'b0;
    pll_lock = 1'b1;

    // asynchronous reset mid-cycle
    #3 rst_ni = 1'b0;
    #1 model_reset();
    check_all("arst");
    step("arst_hold");

    // lock held low long enough for the watchdog, then lock recovers
    pll_lock = 1'b0;
    rst_ni   = 1'b1;
    repeat (1040) step("wdt");
    chk("wdt_flag", lock_timeout, WDT_EN);
    pll_lock = 1'b1;
    repeat (20) step("wdt_clear");
    chk("wdt_cleared", lock_timeout, 1'b0);

    // test mode: domain resets follow rst_ni with no clock
    test_mode = 1'b1;
    #1 rst_ni = 1'b0;
    #1 model_reset();
    chk("tm_low", rst_no, '0);
    check_all("tm_low");
    #1 rst_ni = 1'b1;
    #1 chk("tm_high", rst_no, {N{1'b1}});
    repeat (45) step("tm_run");
    #1 rst_ni = 1'b0;
    #1 model_reset();
    chk("tm_low2", rst_no, '0);
    #1 rst_ni = 1'b1;
    #1 chk("tm_high2", rst_no, {N{1'b1}});
    step("tm_after");
    test_mode = 1'b0;
    repeat (45) step("tm_off");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
